// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller: arbitrates LSB and instruction-fetch requests onto
// one 8-bit RAM port, serialising 1/2/4-byte accesses and returning ok pulses.
module mem_ctrl #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [1:0] IO_TAG     = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  enable_from_lsb,
  input  logic                  read_or_write_from_lsb,
  input  logic [ADDR_WIDTH-1:0] addr_from_lsb,
  input  logic [DATA_WIDTH-1:0] data_from_lsb,
  input  logic [2:0]            width_from_lsb,
  output logic                  ok_to_lsb,
  output logic [DATA_WIDTH-1:0] data_to_lsb,
  input  logic                  enable_from_if,
  input  logic [ADDR_WIDTH-1:0] addr_from_if,
  output logic                  ok_to_if,
  output logic [DATA_WIDTH-1:0] inst_to_if,
  input  logic                  mispredict,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  localparam int NBYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  typedef struct packed {
    logic                  from_if;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [2:0]            n;
  } req_t;

  state_t                state;
  req_t                  req;
  logic [2:0]            k;
  logic                  primed;
  logic [DATA_WIDTH-1:0] rdata;

  logic [2:0]            n_lsb;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic [7:0]            wbyte;
  logic                  rd_last;
  logic                  wr_stall;
  logic                  lsb_stall;

  always_comb begin
    case (width_from_lsb)
      3'd1:    n_lsb = 3'd1;
      3'd2:    n_lsb = 3'd2;
      default: n_lsb = 3'd4;
    endcase
  end

  always_comb begin
    rdata_nxt = rdata;
    wbyte     = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (k == 3'(i)) begin
        rdata_nxt[8*i +: 8] = mem_din;
        wbyte               = req.data[8*i +: 8];
      end
    end
  end

  assign rd_last   = (k == req.n - 3'd1);
  assign wr_stall  = (req.addr[17:16] == IO_TAG) && io_buffer_full;
  assign lsb_stall = (addr_from_lsb[17:16] == IO_TAG) && io_buffer_full;

  // READ spends its first cycle waiting for the RAM's one-cycle latency
  // (primed=0); after that, k is the byte arriving on mem_din this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req         <= '0;
      k           <= '0;
      primed      <= 1'b0;
      rdata       <= '0;
      ok_to_lsb   <= 1'b0;
      ok_to_if    <= 1'b0;
      data_to_lsb <= '0;
      inst_to_if  <= '0;
      mem_dout    <= '0;
      mem_a       <= '0;
      mem_wr      <= 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          ok_to_lsb <= 1'b0;
          ok_to_if  <= 1'b0;
          mem_wr    <= 1'b0;
          if (!mispredict && enable_from_lsb) begin
            req.from_if <= 1'b0;
            req.addr    <= addr_from_lsb;
            req.data    <= data_from_lsb;
            req.n       <= n_lsb;
            primed      <= 1'b0;
            rdata       <= '0;
            mem_a       <= addr_from_lsb;
            if (read_or_write_from_lsb) begin
              state <= WRITE;
              if (lsb_stall) begin
                k <= 3'd0;
              end else begin
                mem_wr   <= 1'b1;
                mem_dout <= data_from_lsb[7:0];
                k        <= 3'd1;
              end
            end else begin
              state <= READ;
              k     <= 3'd0;
            end
          end else if (!mispredict && enable_from_if) begin
            req.from_if <= 1'b1;
            req.addr    <= addr_from_if;
            req.n       <= 3'd4;
            primed      <= 1'b0;
            rdata       <= '0;
            mem_a       <= addr_from_if;
            k           <= 3'd0;
            state       <= READ;
          end
        end
        READ: begin
          if (mispredict) begin
            state <= IDLE;
          end else if (!primed) begin
            primed <= 1'b1;
            if (req.n > 3'd1) mem_a <= req.addr + ADDR_WIDTH'(1);
          end else begin
            rdata <= rdata_nxt;
            k     <= k + 3'd1;
            if (rd_last) begin
              if (req.from_if) begin
                inst_to_if <= rdata_nxt;
                ok_to_if   <= 1'b1;
              end else begin
                data_to_lsb <= rdata_nxt;
                ok_to_lsb   <= 1'b1;
              end
              state <= DONE;
            end else if (k + 3'd2 < req.n) begin
              mem_a <= req.addr + ADDR_WIDTH'(k + 3'd2);
            end
          end
        end
        WRITE: begin
          // Stores are already committed, so mispredict is not looked at here.
          if (k == req.n) begin
            mem_wr    <= 1'b0;
            ok_to_lsb <= 1'b1;
            state     <= DONE;
          end else if (wr_stall) begin
            mem_wr <= 1'b0;
          end else begin
            mem_wr   <= 1'b1;
            mem_a    <= req.addr + ADDR_WIDTH'(k);
            mem_dout <= wbyte;
            k        <= k + 3'd1;
          end
        end
        DONE: begin
          ok_to_lsb <= 1'b0;
          ok_to_if  <= 1'b0;
          mem_wr    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: cycle-exact checks of reads, writes, I/O stall,
// arbitration, mispredict, rdy freeze and reset against hand-computed values.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        enable_from_lsb;
  logic        read_or_write_from_lsb;
  logic [31:0] addr_from_lsb;
  logic [31:0] data_from_lsb;
  logic [2:0]  width_from_lsb;
  logic        ok_to_lsb;
  logic [31:0] data_to_lsb;
  logic        enable_from_if;
  logic [31:0] addr_from_if;
  logic        ok_to_if;
  logic [31:0] inst_to_if;
  logic        mispredict;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ram [0:262143];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .enable_from_lsb(enable_from_lsb),
    .read_or_write_from_lsb(read_or_write_from_lsb),
    .addr_from_lsb(addr_from_lsb), .data_from_lsb(data_from_lsb),
    .width_from_lsb(width_from_lsb),
    .ok_to_lsb(ok_to_lsb), .data_to_lsb(data_to_lsb),
    .enable_from_if(enable_from_if), .addr_from_if(addr_from_if),
    .ok_to_if(ok_to_if), .inst_to_if(inst_to_if),
    .mispredict(mispredict),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only RAM with one-cycle latency; it shares the global enable.
  always @(posedge clk) begin
    if (rdy) mem_din <= (mem_a[31:18] == 14'd0) ? ram[mem_a[17:0]] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic lsb_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] w);
    enable_from_lsb        = 1'b1;
    read_or_write_from_lsb = wr;
    addr_from_lsb          = a;
    data_from_lsb          = d;
    width_from_lsb         = w;
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h00100] = 8'h11; ram[18'h00101] = 8'h22;
    ram[18'h00102] = 8'h33; ram[18'h00103] = 8'h44;
    ram[18'h00200] = 8'hAA; ram[18'h00201] = 8'hBB; ram[18'h00202] = 8'hCC;
    ram[18'h00000] = 8'h01; ram[18'h00001] = 8'h02;
    ram[18'h00002] = 8'h03; ram[18'h00003] = 8'h04;
    ram[18'h00040] = 8'h99; ram[18'h00041] = 8'h98;
    ram[18'h00042] = 8'h97; ram[18'h00043] = 8'h96;
    ram[18'h00080] = 8'h37; ram[18'h00081] = 8'h12;

    rst = 1'b1; rdy = 1'b1; mispredict = 1'b0; io_buffer_full = 1'b0;
    enable_from_lsb = 1'b0; read_or_write_from_lsb = 1'b0;
    addr_from_lsb = '0; data_from_lsb = '0; width_from_lsb = 3'd4;
    enable_from_if = 1'b0; addr_from_if = '0;
    repeat (2) cyc();
    chk("rst_ok_lsb", {31'd0, ok_to_lsb}, 32'd0);
    chk("rst_ok_if",  {31'd0, ok_to_if},  32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr},    32'd0);
    chk("rst_mem_a",  mem_a,              32'd0);
    chk("rst_dout",   {24'd0, mem_dout},  32'd0);
    chk("rst_data",   data_to_lsb,        32'd0);
    chk("rst_inst",   inst_to_if,         32'd0);
    rst = 1'b0;
    cyc();

    // LW 0x100
    lsb_req(1'b0, 32'h100, 32'h0, 3'd4);
    for (int c = 1; c <= 7; c++) begin
      cyc();
      if (c <= 4) chk($sformatf("lw_a%0d", c), mem_a, 32'h100 + 32'(c - 1));
      chk($sformatf("lw_ok%0d", c), {31'd0, ok_to_lsb}, {31'd0, c == 6});
      if (c == 6) begin
        chk("lw_data", data_to_lsb, 32'h44332211);
        enable_from_lsb = 1'b0;
      end
    end

    // SB to I/O space with the sink full for three cycles
    lsb_req(1'b1, 32'h30000, 32'h41, 3'd1);
    io_buffer_full = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      chk($sformatf("sb_wr%0d", c), {31'd0, mem_wr}, {31'd0, c == 4});
      chk($sformatf("sb_ok%0d", c), {31'd0, ok_to_lsb}, {31'd0, c == 5});
      if (c == 4) begin
        chk("sb_a", mem_a, 32'h30000);
        chk("sb_dout", {24'd0, mem_dout}, 32'h41);
      end
      if (c == 3) io_buffer_full = 1'b0;
      if (c == 5) enable_from_lsb = 1'b0;
    end

    // LH and fetch raised together: LSB first, fetch after the DONE gap
    lsb_req(1'b0, 32'h200, 32'h0, 3'd2);
    enable_from_if = 1'b1; addr_from_if = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      chk($sformatf("arb_okl%0d", c), {31'd0, ok_to_lsb}, {31'd0, c == 4});
      chk($sformatf("arb_oki%0d", c), {31'd0, ok_to_if},  {31'd0, c == 11});
      if (c == 4) begin
        chk("arb_lh", data_to_lsb, 32'h0000BBAA);
        enable_from_lsb = 1'b0;
      end
      if (c == 11) begin
        chk("arb_inst", inst_to_if, 32'h04030201);
        enable_from_if = 1'b0;
      end
    end

    // Fetch cancelled by mispredict in cycle 3
    enable_from_if = 1'b1; addr_from_if = 32'h40;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk($sformatf("mp_ok%0d", c), {31'd0, ok_to_if}, 32'd0);
      if (c == 3) mispredict = 1'b1;
      if (c == 4) begin
        chk("mp_a_hold", mem_a, 32'h42);
        mispredict = 1'b0;
        enable_from_if = 1'b0;
      end
    end
    enable_from_if = 1'b1; addr_from_if = 32'h80;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      chk($sformatf("f80_ok%0d", c), {31'd0, ok_to_if}, {31'd0, c == 6});
      if (c == 6) begin
        chk("f80_inst", inst_to_if, 32'h00001237);
        enable_from_if = 1'b0;
      end
    end

    // SW with mispredict mid-write: all bytes still go out
    lsb_req(1'b1, 32'h1000, 32'hDEADBEEF, 3'd4);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      chk($sformatf("sw_wr%0d", c), {31'd0, mem_wr}, {31'd0, c <= 4});
      chk($sformatf("sw_ok%0d", c), {31'd0, ok_to_lsb}, {31'd0, c == 5});
      if (c == 1) chk("sw_b0", {mem_a, 24'd0} | {24'd0, mem_dout}, {32'h1000, 24'd0} | 32'hEF);
      if (c == 2) chk("sw_b1", {24'd0, mem_dout}, 32'hBE);
      if (c == 3) chk("sw_b2", {24'd0, mem_dout}, 32'hAD);
      if (c == 4) begin
        chk("sw_b3", {24'd0, mem_dout}, 32'hDE);
        chk("sw_a3", mem_a, 32'h1003);
      end
      if (c == 2) mispredict = 1'b1;
      if (c == 3) mispredict = 1'b0;
      if (c == 5) enable_from_lsb = 1'b0;
    end

    // LW with rdy low for two cycles
    lsb_req(1'b0, 32'h100, 32'h0, 3'd4);
    for (int c = 1; c <= 9; c++) begin
      cyc();
      chk($sformatf("rdy_ok%0d", c), {31'd0, ok_to_lsb}, {31'd0, c == 8});
      if (c == 8) begin
        chk("rdy_data", data_to_lsb, 32'h44332211);
        enable_from_lsb = 1'b0;
      end
      if (c == 2) rdy = 1'b0;
      if (c == 4) rdy = 1'b1;
    end

    // Reset in the middle of a fetch
    enable_from_if = 1'b1; addr_from_if = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      if (c == 3) rst = 1'b1;
    end
    chk("mr_ok_if", {31'd0, ok_to_if},  32'd0);
    chk("mr_mem_a", mem_a,              32'd0);
    chk("mr_mem_wr", {31'd0, mem_wr},   32'd0);
    chk("mr_dout",  {24'd0, mem_dout},  32'd0);
    chk("mr_data",  data_to_lsb,        32'd0);
    chk("mr_inst",  inst_to_if,         32'd0);
    rst = 1'b0; enable_from_if = 1'b0;
    cyc();

    // LB at 0x101: ok in cycle 3, zero-extended
    lsb_req(1'b0, 32'h101, 32'h0, 3'd1);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk($sformatf("lb_ok%0d", c), {31'd0, ok_to_lsb}, {31'd0, c == 3});
      if (c == 3) begin
        chk("lb_data", data_to_lsb, 32'h00000022);
        enable_from_lsb = 1'b0;
      end
    end

    // Width 3 behaves as a word access
    lsb_req(1'b0, 32'h200, 32'h0, 3'd3);
    for (int c = 1; c <= 7; c++) begin
      cyc();
      chk($sformatf("w3_ok%0d", c), {31'd0, ok_to_lsb}, {31'd0, c == 6});
      if (c == 6) begin
        chk("w3_data", data_to_lsb, 32'h00CCBBAA);
        enable_from_lsb = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller directly downstream of the load/store buffer (LSB).
- Arbitrates between LSB data requests and instruction-fetch (IF) requests onto the single 8-bit RAM port.
- Serialises 1/2/4-byte reads and writes, and returns one-cycle ok pulses with assembled data.
- Stalls I/O writes while the I/O buffer is full, and cancels speculative reads on mispredict.

Parameters:
ADDR_WIDTH, 32, address width of requests and mem_a
DATA_WIDTH, 32, request/response data width
IO_TAG, 2'b11, value of addr[17:16] that marks an I/O address

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
rdy  in  1  global enable; low = freeze all state
enable_from_lsb  in  1  LSB request, held high until ok_to_lsb
read_or_write_from_lsb  in  1  0 read, 1 write
addr_from_lsb  in  32  byte address
data_from_lsb  in  32  store data, low bytes used
width_from_lsb  in  3  byte count, 1/2/4
ok_to_lsb  out  1  one-cycle completion pulse
data_to_lsb  out  32  load data, zero-extended, valid with ok_to_lsb
enable_from_if  in  1  fetch request, held high until ok_to_if
addr_from_if  in  32  fetch address, always 4 bytes
ok_to_if  out  1  one-cycle completion pulse
inst_to_if  out  32  fetched word, valid with ok_to_if
mispredict  in  1  flush of speculative work
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM address
mem_wr  out  1  1 = write
io_buffer_full  in  1  I/O sink cannot accept a byte

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- All outputs are registered.
- Reset values: state IDLE; ok_to_lsb=0, ok_to_if=0, mem_wr=0, mem_a=0, mem_dout=0, data_to_lsb=0, inst_to_if=0.
- rdy=0 holds every register unchanged.
- RAM timing: mem_din in cycle c carries the byte at mem_a of cycle c-1.
- States: IDLE, READ, WRITE, DONE. A byte index k counts from 0 to N-1.
- IDLE:
  - If enable_from_lsb is high, accept the LSB request; LSB has priority over IF.
  - Else if enable_from_if is high, accept the IF request with N=4.
  - On accept: latch source, addr, N, data; k=0; go to READ or WRITE.
  - For a read, drive mem_a=addr, mem_wr=0 on the same edge.
- READ:
  - Each cycle, capture mem_din into byte k of the result, then k++.
  - While bytes remain, drive mem_a=addr+k+1.
  - When byte N-1 is captured, write the full result to data_to_lsb or inst_to_if (upper bytes 0), assert the source ok for one cycle, go to DONE.
  - Latency: enable seen in IDLE cycle 0 gives ok high in cycle N+2 (LW/fetch: cycle 6; LB: cycle 3).
- WRITE:
  - Each cycle drive mem_wr=1, mem_a=addr+k, mem_dout=data[8k+7:8k], then k++.
  - After byte N-1 is driven: next cycle mem_wr=0, ok_to_lsb=1, go to DONE.
  - LSB SW gives ok in cycle 5.
- I/O stall: if addr[17:16]==IO_TAG and io_buffer_full=1, drive mem_wr=0 and hold k. Resume when io_buffer_full is low.
- DONE:
  - Drop ok, mem_wr=0, return to IDLE.
  - Requests are not sampled in DONE, so the requester has one cycle to drop enable.
  - Back-to-back requests therefore have a one-cycle gap.
- Address arithmetic is modulo 2^32; addr+k wraps silently.
- mispredict=1 in READ (either source) aborts to IDLE with no ok pulse and mem_a unchanged.
- mispredict in WRITE is ignored, because stores reach mem_ctrl only after commit.
- mispredict in IDLE blocks acceptance that cycle.
- mispredict in DONE does not retract an ok already driven.
- If ok and mispredict would coincide on the capture edge of the last byte, mispredict wins: no ok.
- Simultaneous LSB and IF requests in IDLE: serve LSB, and IF waits with enable held.
- rst mid-write returns to IDLE immediately; a partially written word is acceptable.
- A width value other than 1/2/4 is treated as 4.

Test Plan:
- LW at 0x100 with RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 in cycles 1-4; ok_to_lsb=1 in cycle 6 only; data_to_lsb=0x44332211.
- SB at 0x30000 with data 0x41, io_buffer_full high for 3 cycles -> mem_wr stays 0 for 3 cycles, then one write of 0x41 at 0x30000; ok_to_lsb one cycle later.
- LSB LH at 0x200 and IF fetch at 0x0 both raised in the same cycle -> LH served first (ok cycle 4, data 0x0000BBAA); IF served after the DONE gap (ok_to_if high 7 cycles after the LH ok).
- IF fetch at 0x40 with mispredict pulsed in cycle 3 -> no ok_to_if; state back in IDLE; a new fetch at 0x80 completes normally in 6 cycles.
- SW of 0xDEADBEEF at 0x1000 with mispredict in cycle 2 -> all 4 bytes written (EF,BE,AD,DE); ok_to_lsb asserted.
- rdy low for 2 cycles mid-LW -> ok delayed by exactly 2 cycles; data unchanged. rst mid-read -> all outputs at reset values on the next cycle.
